// File: rtl/subterranean_rounds_multi_n.sv
// Subterranean 2.0 duplex engine applying up to LANES duplex rounds per beat,
// with a registered one-entry output stage and a self-timed blank-round sequencer.
module subterranean_rounds_multi_n #(
  parameter int LANES        = 2,
  parameter int BLANK_ROUNDS = 8
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic                   init,
  input  logic                   encrypt,
  input  logic                   decrypt,
  input  logic                   blank_start,
  input  logic [3:0]             din_rounds,
  input  logic [32*LANES-1:0]    din,
  input  logic [3*LANES-1:0]     din_size,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic [32*LANES-1:0]    dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   free,
  output logic                   finish
);

  localparam logic [7:0] BLANK_LOAD = 8'(BLANK_ROUNDS);
  localparam logic [3:0] LANES_N    = 4'(LANES);

  // One unkeyed Subterranean round: chi, iota, theta, pi over the 257-bit state.
  function automatic logic [256:0] sbt_round(input logic [256:0] s);
    logic [256:0] a;
    logic [256:0] b;
    logic [256:0] c;
    for (int i = 0; i < 257; i++) begin
      a[9'(i)] = s[9'(i)] ^ (~s[9'((i + 1) % 257)] & s[9'((i + 2) % 257)]);
    end
    a[0] = ~a[0];
    for (int i = 0; i < 257; i++) begin
      b[9'(i)] = a[9'(i)] ^ a[9'((i + 3) % 257)] ^ a[9'((i + 8) % 257)];
    end
    for (int i = 0; i < 257; i++) begin
      c[9'(i)] = b[9'((12 * i) % 257)];
    end
    return c;
  endfunction

  // Inject the 33-bit padded lane at positions 12^(4j) mod 257 (multiplier 176).
  function automatic logic [256:0] sbt_absorb(input logic [256:0] s, input logic [32:0] sig);
    logic [256:0] r;
    int           p;
    r = s;
    p = 1;
    for (int j = 0; j < 33; j++) begin
      r[9'(p)] = r[9'(p)] ^ sig[6'(j)];
      p = (p * 176) % 257;
    end
    return r;
  endfunction

  // Squeeze 32 bits: z_i = s[12^(4i)] ^ s[-12^(4i)].
  function automatic logic [31:0] sbt_extract(input logic [256:0] s);
    logic [31:0] z;
    int          p;
    p = 1;
    for (int i = 0; i < 32; i++) begin
      z[5'(i)] = s[9'(p)] ^ s[9'(257 - p)];
      p = (p * 176) % 257;
    end
    return z;
  endfunction

  // Lane padding: bit 8s for partial lanes, bit 32 for a full lane, raw otherwise.
  function automatic logic [32:0] lane_pad(input logic [31:0] x, input logic [2:0] sz);
    logic [32:0] p;
    p = {1'b0, x};
    case (sz)
      3'd0:    p[0]  = ~p[0];
      3'd1:    p[8]  = ~p[8];
      3'd2:    p[16] = ~p[16];
      3'd3:    p[24] = ~p[24];
      3'd4:    p[32] = 1'b1;
      default: p     = p;
    endcase
    return p;
  endfunction

  // Squeeze mask: only the low s bytes are used for partial encrypt/decrypt lanes.
  function automatic logic [31:0] lane_mask(input logic [2:0] sz, input logic crypt);
    logic [31:0] m;
    if (crypt) begin
      case (sz)
        3'd0:    m = 32'h0000_0000;
        3'd1:    m = 32'h0000_00FF;
        3'd2:    m = 32'h0000_FFFF;
        3'd3:    m = 32'h00FF_FFFF;
        default: m = 32'hFFFF_FFFF;
      endcase
    end else begin
      m = 32'hFFFF_FFFF;
    end
    return m;
  endfunction

  logic [256:0]          state_r;
  logic [7:0]            cnt_r;
  logic                  free_r;
  logic                  finish_r;
  logic [32*LANES-1:0]   dout_r;
  logic                  dout_valid_r;

  logic                  blank_run_s;
  logic                  din_ready_s;
  logic                  accept_s;
  logic                  crypt_s;
  logic                  dec_s;
  logic [3:0]            rounds_s;
  logic [256:0]          chain_s;
  logic [256:0]          next_state_s;
  logic [32*LANES-1:0]   lane_out_s;
  logic [31:0]           lane_x_s;
  logic [2:0]            lane_sz_s;
  logic [31:0]           lane_sq_s;
  logic [31:0]           lane_y_s;
  logic [31:0]           lane_ab_s;

  assign blank_run_s = (cnt_r != 8'd0);
  assign din_ready_s = free_r & ~blank_start & ~init & (~dout_valid_r | dout_ready);
  assign accept_s    = din_valid & din_ready_s;
  assign crypt_s     = (encrypt | decrypt) & ~blank_run_s;
  assign dec_s       = decrypt & ~blank_run_s;

  // Number of rounds this cycle: blank counter or din_rounds, clamped to LANES.
  always_comb begin
    rounds_s = 4'd0;
    if (blank_run_s) begin
      if (cnt_r > {4'd0, LANES_N}) rounds_s = LANES_N;
      else                         rounds_s = cnt_r[3:0];
    end else begin
      if (din_rounds > LANES_N) rounds_s = LANES_N;
      else                      rounds_s = din_rounds;
    end
  end

  // Round chain: lane k is squeezed from and absorbed by round k+1; tap after rounds_s rounds.
  always_comb begin
    chain_s      = state_r;
    next_state_s = state_r;
    lane_out_s   = din;
    lane_x_s     = 32'd0;
    lane_sz_s    = 3'd0;
    lane_sq_s    = 32'd0;
    lane_y_s     = 32'd0;
    lane_ab_s    = 32'd0;
    for (int k = 0; k < LANES; k++) begin
      if (blank_run_s) begin
        lane_x_s  = 32'd0;
        lane_sz_s = 3'd0;
      end else begin
        lane_x_s  = din[32*k +: 32];
        lane_sz_s = din_size[3*k +: 3];
      end
      lane_sq_s = sbt_extract(chain_s);
      lane_y_s  = lane_x_s ^ (lane_sq_s & lane_mask(lane_sz_s, crypt_s));
      if (dec_s) lane_ab_s = lane_y_s;
      else       lane_ab_s = lane_x_s;
      chain_s = sbt_absorb(sbt_round(chain_s), lane_pad(lane_ab_s, lane_sz_s));
      if (k < int'(rounds_s)) begin
        lane_out_s[32*k +: 32] = lane_y_s;
      end else begin
        lane_out_s[32*k +: 32] = lane_x_s;
      end
      if (k + 1 == int'(rounds_s)) next_state_s = chain_s;
      else                         next_state_s = next_state_s;
    end
  end

  // State, blank sequencer and completion pulse; init outranks blank_start and data.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_r  <= 257'd0;
      cnt_r    <= 8'd0;
      free_r   <= 1'b1;
      finish_r <= 1'b0;
    end else begin
      finish_r <= 1'b0;
      if (init) begin
        state_r <= 257'd0;
        cnt_r   <= 8'd0;
        free_r  <= 1'b1;
      end else if (blank_run_s) begin
        state_r <= next_state_s;
        cnt_r   <= cnt_r - {4'd0, rounds_s};
        if (cnt_r == {4'd0, rounds_s}) begin
          free_r   <= 1'b1;
          finish_r <= 1'b1;
        end
      end else if (blank_start) begin
        cnt_r  <= BLANK_LOAD;
        free_r <= 1'b0;
      end else if (accept_s) begin
        state_r  <= next_state_s;
        finish_r <= 1'b1;
      end
    end
  end

  // One-entry output stage; refills in the same cycle it drains.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
    end else if (accept_s) begin
      dout_r       <= lane_out_s;
      dout_valid_r <= 1'b1;
    end else if (dout_ready) begin
      dout_valid_r <= 1'b0;
    end
  end

  assign din_ready  = din_ready_s;
  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign free       = free_r;
  assign finish     = finish_r;

endmodule

// File: doc/subterranean_rounds_multi_n.md
# subterranean_rounds_multi_n

Parametrised Subterranean 2.0 duplex engine.
- Applies 1..LANES duplex rounds per accepted beat, one 32-bit lane per round.
- Registers the squeezed/encrypted output behind a one-entry valid/ready stage.
- Contains a self-timed blank-round sequencer (BLANK_ROUNDS empty duplex calls), so the controller issues blank phases with one pulse.
- Sits between the AEAD/hash controller and the combinational `subterranean_round` instances.

## Interface
- LANES, 2, rounds per cycle / 32-bit lanes per beat; legal 1..8.
- BLANK_ROUNDS, 8, empty duplex calls per blank phase; legal 1..255.

Ports:
- clk  in  1  clock.
- arstn  in  1  asynchronous active-low reset.
- init  in  1  zero the 257-bit state; highest priority.
- encrypt  in  1  mask squeeze bytes to lane byte count; output = din ^ masked squeeze.
- decrypt  in  1  as encrypt, and absorb (din ^ masked squeeze) instead of din.
- blank_start  in  1  pulse; start blank phase. Sampled only while free=1.
- din_rounds  in  4  rounds to apply this beat. 0 = no state update; >LANES clamps to LANES.
- din  in  32*LANES  lane i = din[32i+31:32i], absorbed by round i+1.
- din_size  in  3*LANES  lane i byte count = din_size[3i+2:3i].
- din_valid  in  1  input beat valid.
- din_ready  out  1  input beat accepted when din_valid & din_ready.
- dout  out  32*LANES  registered lane outputs.
- dout_valid  out  1  output register full.
- dout_ready  in  1  output consumed when dout_valid & dout_ready.
- free  out  1  no blank phase running.
- finish  out  1  one-cycle pulse after each completed beat or blank phase.

## Operation
- **State:** 257-bit register, reset to 0, and set to 0 on init.
- **Round chain:** round k takes round k-1's output; round 1 takes the state register. The state loads the output of round din_rounds.
- **Lane padding**, byte count s = 0..3:
  - XOR 1 into bit 8s of the lane; bit 32 = 0.
  - s=4: bit 32 = 1.
  - s=5..7: no padding; data absorbed raw; bit 32 = 0.
- **Output mask**, only when encrypt|decrypt and s<4: low s bytes set (0, 0xFF, 0xFFFF, 0xFFFFFF). Otherwise 0xFFFFFFFF.
- **dout lane i** = din lane i ^ (round i+1 squeeze & mask). Lanes at or beyond din_rounds output din unchanged.
- **Blank phase:**
  - Every lane is absorbed as s=0 (din=0, bit 0 set). Output is discarded.
  - Down-counter loaded with BLANK_ROUNDS; each cycle applies min(counter, LANES) rounds and subtracts that count.
  - The phase lasts ceil(BLANK_ROUNDS/LANES) cycles. free=0 throughout.
- **din_ready** = free & ~blank_start & ~init & (~dout_valid | dout_ready).
- **Priority:** init > blank_start > data beat.
  - init during a blank phase aborts it: counter=0, free=1 next cycle, no finish pulse.
  - init does not clear a pending dout.
- **Reset:** dout_valid=0, dout=0, finish=0, free=1, counter=0, state=0.

## Timing
- **Data beat** accepted at edge t:
  - State updated at t+1.
  - dout/dout_valid registered at t+1.
  - finish=1 during cycle t+1 only.
- **Output register:**
  - Holds while dout_valid & ~dout_ready.
  - Supports back-to-back beats: it is refilled in the same cycle it drains, giving full throughput of 1 beat/cycle.
- **Blank phase:**
  - blank_start sampled at t: free=0 from t+1 through t+C, where C=ceil(BLANK_ROUNDS/LANES).
  - free=1 at t+C+1, with finish pulse in the same cycle.
- blank_start while free=0 is ignored.
- din_valid may stay high during a blank phase; the beat waits (din_ready=0).
- Reset mid-phase: all control returns to reset values asynchronously; no finish pulse.

## Test plan
- **Blank phase, LANES=2, BLANK_ROUNDS=8:**
  - Stimulus: init, then blank_start.
  - Required: free low exactly 4 cycles; finish single pulse as free rises; state equals golden model after 8 blank rounds.
  - Repeat with LANES=3: 3 cycles, last cycle applies 2 rounds.
- **Encrypt partial lane, LANES=2:**
  - Stimulus: din=0x00000000_AABBCCDD, din_size lane0=2, lane1=5, din_rounds=1.
  - Required: dout[31:16]=0xAABB; dout[15:0]=0xCCDD ^ squeeze[15:0]; dout[63:32]=0; state matches golden model for 1 round.
- **Round-trip:**
  - Stimulus: encrypt 64 random bytes with s=4 on all lanes, then re-init and decrypt the ciphertext.
  - Required: plaintext recovered; final states bit-identical.
- **Backpressure:**
  - Stimulus: hold dout_ready=0 for 3 cycles with din_valid=1.
  - Required: dout stable; din_ready=0 after the first beat; on release, beats are accepted 1/cycle with no loss or duplication.
- **din_rounds boundaries:**
  - Stimulus: din_rounds=0, then din_rounds=9 with LANES=2.
  - Required: 0 → state unchanged but finish pulses; 9 → identical result to din_rounds=2.
- **Abort paths:**
  - Stimulus: init on cycle 2 of a blank phase, and arstn low on cycle 2 of another.
  - Required: free=1 next cycle (immediately for reset); no finish pulse; counter=0; next blank_start restarts a full phase.
